// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and types for the core data-memory responder
package cpu_pkg;

    localparam logic [3:0]  MMIO_CON_TX = 4'h0;
    localparam logic [3:0]  MMIO_STATUS = 4'h4;
    localparam logic [3:0]  MMIO_CYCLE  = 4'h8;
    localparam logic [3:0]  MMIO_TOHOST = 4'hC;

    localparam logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_MMIO,
        REG_NONE
    } region_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with registered head, async active-high reset
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data RAM plus MMIO console/status/cycle/tohost for the single-cycle core
module data_mem_responder
    import cpu_pkg::*;
#(
    parameter logic [31:0] RAM_BASE   = 32'h0001_0000,
    parameter int          RAM_WORDS  = 1024,
    parameter logic [31:0] MMIO_BASE  = 32'h8000_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] cpu_data_addr_i,
    output logic [31:0] cpu_data_rdata_o,
    input  logic [31:0] cpu_data_wdata_i,
    input  logic        cpu_data_re_i,
    input  logic        cpu_data_we_i,
    output logic [7:0]  con_data_o,
    output logic        con_valid_o,
    input  logic        con_ready_i,
    output logic [31:0] tohost_o,
    output logic        tohost_valid_o,
    output logic        error_o
);

    localparam int IDX_W = $clog2(RAM_WORDS);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]      ram [RAM_WORDS];
    logic [29:0]      ram_woff;
    logic [29:0]      mmio_woff;
    logic [IDX_W-1:0] ram_idx;
    logic [3:0]       mmio_sel;
    region_e          region;
    logic             bad_access;
    logic             legal_wr;
    logic             legal_rd;
    logic             ram_wr;
    logic             mmio_wr;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [7:0]       free_entries;
    logic             overflow;
    logic [31:0]      cycle;
    logic [31:0]      mmio_rdata;

    // Decode on word offsets so the byte-lane bits only feed the alignment check.
    assign ram_woff  = cpu_data_addr_i[31:2] - RAM_BASE[31:2];
    assign mmio_woff = cpu_data_addr_i[31:2] - MMIO_BASE[31:2];
    assign ram_idx   = ram_woff[IDX_W-1:0];
    assign mmio_sel  = {mmio_woff[1:0], 2'b00};

    always_comb begin
        region = REG_NONE;
        if (ram_woff[29:IDX_W] == '0)
            region = REG_RAM;
        else if (mmio_woff[29:2] == '0)
            region = REG_MMIO;
    end

    assign bad_access = (cpu_data_re_i || cpu_data_we_i) &&
                        ((cpu_data_addr_i[1:0] != 2'b00) || (region == REG_NONE) ||
                         (cpu_data_re_i && cpu_data_we_i));
    assign legal_wr   = cpu_data_we_i && !bad_access;
    assign legal_rd   = cpu_data_re_i && !bad_access;
    assign ram_wr     = legal_wr && (region == REG_RAM);
    assign mmio_wr    = legal_wr && (region == REG_MMIO);
    assign fifo_push  = mmio_wr && (mmio_sel == MMIO_CON_TX);
    assign fifo_pop   = con_valid_o && con_ready_i;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_con_fifo (
        .clk       (clk_i),
        .rst       (reset_i),
        .push      (fifo_push),
        .push_data (cpu_data_wdata_i[7:0]),
        .pop       (fifo_pop),
        .head      (con_data_o),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign con_valid_o  = !fifo_empty;
    assign free_entries = 8'(FIFO_DEPTH) - 8'(fifo_count);

    always_ff @(posedge clk_i) begin
        if (ram_wr) ram[ram_idx] <= cpu_data_wdata_i;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cycle          <= '0;
            overflow       <= 1'b0;
            tohost_o       <= '0;
            tohost_valid_o <= 1'b0;
            error_o        <= 1'b0;
        end else begin
            cycle          <= cycle + 32'd1;
            tohost_valid_o <= mmio_wr && (mmio_sel == MMIO_TOHOST);
            if (mmio_wr && (mmio_sel == MMIO_TOHOST))
                tohost_o <= cpu_data_wdata_i;
            if (fifo_push && fifo_full && !fifo_pop)
                overflow <= 1'b1;
            else if (mmio_wr && (mmio_sel == MMIO_STATUS) && cpu_data_wdata_i[3])
                overflow <= 1'b0;
            if (bad_access)
                error_o <= 1'b1;
        end
    end

    always_comb begin
        mmio_rdata = '0;
        case (mmio_sel)
            MMIO_CON_TX: mmio_rdata = {24'h0, free_entries};
            MMIO_STATUS: mmio_rdata = {28'h0, overflow, fifo_full, fifo_empty, 1'b0};
            MMIO_CYCLE:  mmio_rdata = cycle;
            MMIO_TOHOST: mmio_rdata = tohost_o;
            default:     mmio_rdata = '0;
        endcase
    end

    always_comb begin
        cpu_data_rdata_o = '0;
        if (bad_access)
            cpu_data_rdata_o = ERR_RDATA;
        else if (legal_rd && (region == REG_RAM))
            cpu_data_rdata_o = ram[ram_idx];
        else if (legal_rd && (region == REG_MMIO))
            cpu_data_rdata_o = mmio_rdata;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
module tb_data_mem_responder;

    localparam logic [31:0] RB = 32'h0001_0000;
    localparam logic [31:0] MB = 32'h8000_0000;
    localparam logic [31:0] A_CON = MB + 32'h0;
    localparam logic [31:0] A_STS = MB + 32'h4;
    localparam logic [31:0] A_CYC = MB + 32'h8;
    localparam logic [31:0] A_TOH = MB + 32'hC;
    localparam logic [31:0] BEEF  = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] rdata;
    logic [31:0] wdata = '0;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic [7:0]  con_data;
    logic        con_valid;
    logic        con_ready = 1'b0;
    logic [31:0] tohost;
    logic        tohost_valid;
    logic        error;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_ram [1024];
    bit          m_vld [1024];
    logic [7:0]  mq [$];
    bit          m_ovf;

    always #5 clk = ~clk;

    data_mem_responder dut (
        .clk_i            (clk),
        .reset_i          (rst),
        .cpu_data_addr_i  (addr),
        .cpu_data_rdata_o (rdata),
        .cpu_data_wdata_i (wdata),
        .cpu_data_re_i    (re),
        .cpu_data_we_i    (we),
        .con_data_o       (con_data),
        .con_valid_o      (con_valid),
        .con_ready_i      (con_ready),
        .tohost_o         (tohost),
        .tohost_valid_o   (tohost_valid),
        .error_o          (error)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic        w;
        logic        r;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; we = 1'b1; re = 1'b0;
        @(posedge clk);
        #1 we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; re = 1'b1; we = 1'b0;
        #1 d = rdata;
        @(posedge clk);
        #1 re = 1'b0;
    endtask

    // Drains the console with ready held high, comparing against the model queue.
    task automatic drain_q();
        int n;
        n = mq.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            con_ready = 1'b1;
            #1;
            chk($sformatf("drain%0d_valid", i), 32'(con_valid), 32'd1);
            chk($sformatf("drain%0d_data", i), 32'(con_data), 32'(mq[0]));
            void'(mq.pop_front());
        end
        @(negedge clk);
        con_ready = 1'b0;
        #1 chk("drain_empty", 32'(con_valid), 32'd0);
    endtask

    vec_t        vecs [$];
    logic [31:0] v;
    logic [31:0] c1;
    logic [31:0] c2;

    initial begin
        vecs.push_back('{RB + 32'h8,    32'hCAFE_0001, 1'b1, 1'b0, 1'b1, 32'h0,         1'b0});
        vecs.push_back('{RB + 32'h8,    32'h0,         1'b0, 1'b1, 1'b1, 32'hCAFE_0001, 1'b0});
        vecs.push_back('{RB + 32'hFFC,  32'h1234_5678, 1'b1, 1'b0, 1'b1, 32'h0,         1'b0});
        vecs.push_back('{RB + 32'hFFC,  32'h0,         1'b0, 1'b1, 1'b1, 32'h1234_5678, 1'b0});
        vecs.push_back('{A_STS,         32'h0,         1'b0, 1'b1, 1'b1, 32'h2,         1'b0});
        vecs.push_back('{A_CON,         32'h0,         1'b0, 1'b1, 1'b1, 32'h8,         1'b0});
        vecs.push_back('{A_TOH,         32'h0,         1'b0, 1'b1, 1'b1, 32'h0,         1'b0});
        vecs.push_back('{RB + 32'h8,    32'h0,         1'b0, 1'b0, 1'b1, 32'h0,         1'b0});
        vecs.push_back('{RB + 32'h2,    32'h0,         1'b0, 1'b1, 1'b1, BEEF,          1'b1});
        vecs.push_back('{32'h4000_0000, 32'h5555_5555, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1});
        vecs.push_back('{RB + 32'h8,    32'h0,         1'b0, 1'b1, 1'b1, 32'hCAFE_0001, 1'b1});
        vecs.push_back('{RB + 32'h1000, 32'h0,         1'b0, 1'b1, 1'b1, BEEF,          1'b1});
        vecs.push_back('{MB + 32'h10,   32'h0,         1'b0, 1'b1, 1'b1, BEEF,          1'b1});
        vecs.push_back('{RB + 32'h8,    32'h0BAD_0BAD, 1'b1, 1'b1, 1'b1, BEEF,          1'b1});
        vecs.push_back('{RB + 32'h8,    32'h0,         1'b0, 1'b1, 1'b1, 32'hCAFE_0001, 1'b1});

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        addr = A_CYC; re = 1'b1;
        #1 chk("rst_cycle", rdata, 32'h0);
        chk("rst_con_valid", 32'(con_valid), 32'd0);
        chk("rst_tohost", tohost, 32'h0);
        chk("rst_tohost_valid", 32'(tohost_valid), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        re = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            addr = vecs[i].a; wdata = vecs[i].d; we = vecs[i].w; re = vecs[i].r;
            #1;
            if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rd);
            @(posedge clk);
            #1 we = 1'b0; re = 1'b0;
            chk($sformatf("vec%0d_error", i), 32'(error), 32'(vecs[i].exp_err));
        end

        m_ram[2] = 32'hCAFE_0001;    m_vld[2] = 1'b1;
        m_ram[1023] = 32'h1234_5678; m_vld[1023] = 1'b1;
        for (int i = 0; i < 200; i++) begin
            int idx;
            int op;
            idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1000, 1023)) : int'($urandom_range(0, 31));
            op = int'($urandom_range(0, 3));
            if (op == 3) begin
                rd(RB + 32'(idx * 4) + 32'($urandom_range(1, 3)), v);
                chk($sformatf("rnd%0d_misaligned", i), v, BEEF);
            end else if (op == 2 && m_vld[idx]) begin
                rd(RB + 32'(idx * 4), v);
                chk($sformatf("rnd%0d_ram[%0d]", i, idx), v, m_ram[idx]);
            end else begin
                m_ram[idx] = $urandom;
                m_vld[idx] = 1'b1;
                wr(RB + 32'(idx * 4), m_ram[idx]);
            end
        end

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            addr = A_CON; wdata = 32'h41 + 32'(i); we = 1'b1;
            #1 if (i == 0) chk("push_first_no_fallthrough", 32'(con_valid), 32'd0);
            @(posedge clk);
            #1 we = 1'b0;
            if (i == 0) chk("push_first_valid_next", 32'(con_valid), 32'd1);
            if (i < 8) mq.push_back(8'h41 + 8'(i));
        end
        rd(A_STS, v); chk("ovf_status", v, 32'hC);
        rd(A_CON, v); chk("ovf_free", v, 32'h0);
        drain_q();
        wr(A_STS, 32'h8);
        rd(A_STS, v); chk("ovf_cleared", v, 32'h2);

        for (int i = 0; i < 8; i++) begin
            wr(A_CON, 32'h61 + 32'(i));
            mq.push_back(8'h61 + 8'(i));
        end
        rd(A_STS, v); chk("full_status", v, 32'h4);
        @(negedge clk);
        addr = A_CON; wdata = 32'h5A; we = 1'b1; con_ready = 1'b1;
        #1 chk("fullpp_head", 32'(con_data), 32'h61);
        @(posedge clk);
        #1 we = 1'b0; con_ready = 1'b0;
        void'(mq.pop_front());
        mq.push_back(8'h5A);
        rd(A_CON, v); chk("fullpp_free", v, 32'h0);
        rd(A_STS, v); chk("fullpp_status", v, 32'h4);
        drain_q();

        @(negedge clk);
        addr = A_TOH; wdata = 32'h1; we = 1'b1;
        #1 chk("tohost_pre", 32'(tohost_valid), 32'd0);
        @(posedge clk);
        #1 we = 1'b0;
        chk("tohost_val", tohost, 32'h1);
        chk("tohost_pulse", 32'(tohost_valid), 32'd1);
        @(posedge clk);
        #1 chk("tohost_pulse_end", 32'(tohost_valid), 32'd0);
        rd(A_TOH, v); chk("tohost_read", v, 32'h1);

        rd(A_CYC, c1);
        repeat (6) @(posedge clk);
        rd(A_CYC, c2);
        chk("cycle_delta", c2 - c1, 32'd7);

        m_ovf = 1'b0;
        for (int i = 0; i < 300; i++) begin
            bit p;
            bit r;
            bit pop;
            logic [7:0] b;
            p = ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 2) == 0);
            b = 8'($urandom);
            @(negedge clk);
            addr = A_CON; wdata = {24'h0, b}; we = p; con_ready = r;
            #1;
            chk($sformatf("rf%0d_valid", i), 32'(con_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) chk($sformatf("rf%0d_data", i), 32'(con_data), 32'(mq[0]));
            pop = r && (mq.size() != 0);
            @(posedge clk);
            #1 we = 1'b0; con_ready = 1'b0;
            if (p && mq.size() == 8 && !pop) m_ovf = 1'b1;
            if (pop) void'(mq.pop_front());
            if (p && (mq.size() < 8)) mq.push_back(b);
        end
        rd(A_STS, v);
        chk("rf_status", v, {28'h0, m_ovf, mq.size() == 8, mq.size() == 0, 1'b0});
        rd(A_CON, v);
        chk("rf_free", v, 32'(8 - mq.size()));
        drain_q();
        wr(A_STS, 32'h8);

        for (int i = 0; i < 3; i++) wr(A_CON, 32'h30 + 32'(i));
        chk("pre_rst_valid", 32'(con_valid), 32'd1);
        @(negedge clk);
        addr = A_TOH; wdata = 32'h7; we = 1'b1;
        @(posedge clk);
        #1 we = 1'b0;
        chk("pre_rst_pulse", 32'(tohost_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_con_valid", 32'(con_valid), 32'd0);
        chk("rst_mid_pulse", 32'(tohost_valid), 32'd0);
        chk("rst_mid_error", 32'(error), 32'd0);
        chk("rst_mid_tohost", tohost, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        addr = A_CYC; re = 1'b1;
        #1 chk("post_rst_cycle", rdata, 32'h0);
        addr = A_STS;
        #1 chk("post_rst_status", rdata, 32'h2);
        re = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
